jtag_scan_master: RTL and testbench

- Host-side JTAG TAP driver: generates TCK/TMS/TDI and samples TDO, so a debug module target can be scanned from on-chip logic or a self-test harness.
- Accepts one IR or DR scan command of 1..38 bits and drives the full TAP walk from Run-Test/Idle back to Run-Test/Idle.
- Returns the captured TDO bits as a response.
- Sits between a command source (sequencer or bus slave) and the target TAP pins.

---
 rtl/jtag_scan_master.sv | 163 ++++++++++++++++
 tb/tb_jtag_scan_master.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_master.sv
// Host-side JTAG TAP driver: walks Run-Test/Idle -> IR/DR shift -> Run-Test/Idle
// for one command of 1..MAX_LEN bits and returns the captured TDO bits.
module jtag_scan_master #(
  parameter int MAX_LEN = 38,
  parameter int LEN_W   = 6,
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_is_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_SEL, S_CAP, S_SHIFT, S_EXIT, S_UPD, S_RESP, S_ERR
  } state_t;

  state_t state, next_state;

  logic [DIV_W-1:0]   div_cnt;
  logic [LEN_W-1:0]   step;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_m1;
  logic               is_ir_q;
  logic [MAX_LEN-1:0] sr;
  logic [MAX_LEN-1:0] rsp_q;
  logic               tck_r, tms_r, tdi_r;

  logic active, div_end, tck_rise, tck_fall, last, len_ok;
  logic first_tms, cont_tms;

  assign active = (state == S_INIT) || (state == S_SEL) || (state == S_CAP) ||
                  (state == S_SHIFT) || (state == S_EXIT) || (state == S_UPD);
  assign div_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign tck_rise = active && !tck_r && div_end;
  assign tck_fall = active && tck_r && div_end;
  assign len_m1   = len_q - LEN_W'(1);
  assign len_ok   = (cmd_len != '0) && (cmd_len <= LEN_W'(MAX_LEN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_INIT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    last       = 1'b0;
    case (state)
      S_INIT:        last = (step == LEN_W'(5));
      S_SEL:         last = (step == (is_ir_q ? LEN_W'(1) : LEN_W'(0)));
      S_CAP:         last = (step == LEN_W'(1));
      S_SHIFT:       last = (step == len_m1);
      S_EXIT, S_UPD: last = 1'b1;
      default:       last = 1'b0;
    endcase
    case (state)
      S_INIT:  if (tck_fall && last) next_state = S_IDLE;
      S_IDLE:  if (cmd_valid)        next_state = len_ok ? S_SEL : S_ERR;
      S_SEL:   if (tck_fall && last) next_state = S_CAP;
      S_CAP:   if (tck_fall && last) next_state = S_SHIFT;
      S_SHIFT: if (tck_fall && last) next_state = S_EXIT;
      S_EXIT:  if (tck_fall)         next_state = S_UPD;
      S_UPD:   if (tck_fall)         next_state = S_RESP;
      S_RESP, S_ERR: if (rsp_ready)  next_state = S_IDLE;
      default: next_state = S_INIT;
    endcase
  end

  // tms for the TCK that starts after this falling edge
  always_comb begin
    first_tms = 1'b0;
    case (next_state)
      S_SEL:   first_tms = 1'b1;
      S_SHIFT: first_tms = (len_q == LEN_W'(1));
      S_EXIT:  first_tms = 1'b1;
      default: first_tms = 1'b0;
    endcase
    cont_tms = 1'b0;
    case (state)
      S_INIT:  cont_tms = (step < LEN_W'(4));
      S_SEL:   cont_tms = 1'b1;
      S_SHIFT: cont_tms = ((step + LEN_W'(1)) == len_m1);
      default: cont_tms = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tck_r   <= 1'b0;
      tms_r   <= 1'b1;
      tdi_r   <= 1'b0;
      step    <= '0;
      len_q   <= '0;
      is_ir_q <= 1'b0;
      sr      <= '0;
      rsp_q   <= '0;
    end else begin
      if (!active) begin
        div_cnt <= '0;
        tck_r   <= 1'b0;
      end else if (div_end) begin
        div_cnt <= '0;
        tck_r   <= ~tck_r;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (state == S_IDLE && cmd_valid) begin
        is_ir_q <= cmd_is_ir;
        len_q   <= cmd_len;
        sr      <= cmd_data;
        rsp_q   <= '0;
        step    <= '0;
        tdi_r   <= 1'b0;
        tms_r   <= len_ok;
      end

      if (tck_rise && state == S_SHIFT) rsp_q[step] <= tdo;

      if (tck_fall) begin
        if (last) begin
          step  <= '0;
          tms_r <= first_tms;
          tdi_r <= (next_state == S_SHIFT) ? sr[0] : 1'b0;
        end else begin
          step  <= step + LEN_W'(1);
          tms_r <= cont_tms;
          if (state == S_SHIFT) begin
            tdi_r <= sr[1];
            sr    <= sr >> 1;
          end else begin
            tdi_r <= 1'b0;
          end
        end
      end
    end
  end

  assign tck       = tck_r;
  assign tms       = tms_r;
  assign tdi       = tdi_r;
  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP) || (state == S_ERR);
  assign rsp_err   = (state == S_ERR);
  assign rsp_data  = rsp_q;
  assign busy      = active;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Scoreboard bench for jtag_scan_master: stimulus pushes expected responses,
// a negedge monitor pops and compares on each response handshake.
module tb_jtag_scan_master;
  localparam int MAX_LEN = 38;
  localparam int LEN_W   = 6;
  localparam int CLK_DIV = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_is_ir = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic rsp_valid, rsp_ready = 1'b1, rsp_err, busy, tck, tms, tdi, tdo;
  logic [MAX_LEN-1:0] rsp_data;

  logic [1:0] tdo_mode = 2'd0;   // 0/1 = tied, 2 = loop through TCK flop
  logic loop_ff = 1'b0;
  assign tdo = (tdo_mode == 2'd2) ? loop_ff : tdo_mode[0];

  jtag_scan_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_ir(cmd_is_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;

  int tck_rises = 0;
  bit tms_hist[$];
  always @(posedge tck) begin
    tck_rises++;
    tms_hist.push_back(tms);
    loop_ff <= tdi;
  end

  typedef struct { logic [MAX_LEN-1:0] data; logic err; } rsp_t;
  rsp_t sb[$];

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  always @(negedge clk) begin : monitor
    rsp_t e;
    if (reset === 1'b0 && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: got data %0h err %0b expected no response",
                 rsp_data, rsp_err);
      end else begin
        e = sb.pop_front();
        chk("rsp_data", 64'(rsp_data), 64'(e.data));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  task automatic push_exp(logic [MAX_LEN-1:0] d, logic err);
    rsp_t e;
    e.data = d;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic issue(bit ir, int len, logic [MAX_LEN-1:0] data);
    bit ok = 0;
    @(posedge clk) #1;
    cmd_is_ir = ir;
    cmd_len   = len[LEN_W-1:0];
    cmd_data  = data;
    cmd_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) chk("cmd_accept_timeout", 64'd0, 64'd1);
    @(posedge clk) #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(string name);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) begin ok = 1; break; end
    end
    if (!ok) chk({name, "_rsp_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic check_tms(string name, int s, bit ir, int len);
    logic [63:0] e = '0;
    logic [63:0] g = '0;
    int p = 0;
    int n = tck_rises - s;
    chk({name, "_tck_count"}, 64'(n), 64'(ir ? len + 6 : len + 5));
    e[p] = 1'b1; p++;
    if (ir) begin e[p] = 1'b1; p++; end
    p += 2 + len - 1;
    e[p] = 1'b1; p++;
    e[p] = 1'b1;
    for (int i = 0; i < n && i < 64; i++) g[i] = tms_hist[s + i];
    chk({name, "_tms_pattern"}, g, e);
  endtask

  task automatic scan(string name, bit ir, int len, logic [MAX_LEN-1:0] data,
                      logic [MAX_LEN-1:0] exp);
    int s = tck_rises;
    push_exp(exp, 1'b0);
    issue(ir, len, data);
    wait_drain(name);
    check_tms(name, s, ir, len);
  endtask

  task automatic err_cmd(string name, int len);
    int s = tck_rises;
    push_exp('0, 1'b1);
    issue(1'b0, len, 38'h3F_FFFF_FFFF);
    wait_drain(name);
    chk({name, "_no_tck"}, 64'(tck_rises - s), 64'd0);
  endtask

  task automatic init_check(string name);
    int s = tck_rises;
    int cyc = 0;
    logic [63:0] g = '0;
    @(negedge clk) reset = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin cyc = i; break; end
    end
    chk({name, "_ready_cycles"}, 64'(cyc), 64'(12 * CLK_DIV));
    chk({name, "_tck_count"}, 64'(tck_rises - s), 64'd6);
    for (int i = 0; i < 6 && s + i < tms_hist.size(); i++) g[i] = tms_hist[s + i];
    chk({name, "_tms_pattern"}, g, 64'h1F);
  endtask

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    chk("reset_tck", 64'(tck), 64'd0);
    chk("reset_tms", 64'(tms), 64'd1);
    chk("reset_tdi", 64'(tdi), 64'd0);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
    chk("reset_busy", 64'(busy), 64'd1);
    init_check("init");
    chk("idle_busy", 64'(busy), 64'd0);

    tdo_mode = 2'd2;
    scan("dr38_loop", 1'b0, 38, 38'h2A_5555_AAAA, 38'h14_AAAB_5554);
    tdo_mode = 2'd1;
    scan("ir2_tdo1", 1'b1, 2, 38'h2, 38'h3);

    err_cmd("len0", 0);
    err_cmd("len39", 39);

    // response back-pressure; a second command is offered while the first waits
    @(posedge clk) #1 rsp_ready = 1'b0;
    push_exp(38'h1, 1'b0);
    issue(1'b0, 1, 38'h1);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    if (!ok) chk("hold_rsp_timeout", 64'd0, 64'd1);
    @(posedge clk) #1;
    cmd_is_ir = 1'b0; cmd_len = 6'd3; cmd_data = 38'h5; cmd_valid = 1'b1;
    push_exp(38'h7, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rsp_data", 64'(rsp_data), 64'h1);
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    @(posedge clk) #1 rsp_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) chk("second_cmd_timeout", 64'd0, 64'd1);
    @(posedge clk) #1 cmd_valid = 1'b0;
    wait_drain("second_cmd");

    // reset during shift bit 5 of a 20-bit DR scan (shift bit k is TCK 3+k)
    begin
      int s;
      tdo_mode = 2'd2;
      s = tck_rises;
      issue(1'b0, 20, 38'hF_1234);
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
        @(posedge clk);
        if (tck_rises >= s + 9) begin ok = 1; break; end
      end
      if (!ok) chk("abort_wait_timeout", 64'd0, 64'd1);
      #1 reset = 1'b1;
      #1;
      chk("abort_tck", 64'(tck), 64'd0);
      chk("abort_tms", 64'(tms), 64'd1);
      chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd1);
      repeat (3) @(negedge clk);
      init_check("reinit");
      repeat (40) @(negedge clk);
      chk("abort_no_pending", 64'(sb.size()), 64'd0);
      chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
    end

    scan("dr4_after_reinit", 1'b0, 4, 38'hA, 38'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
